// File: rtl/bus_sync_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_sync_ctrl_if
// Groups the source-side bus, the consumer handshake and the status outputs
// of bus_sync_ctrl into one bundle.
//   master : environment side (drives source bus, enable, ready, clear)
//   slave  : bus_sync_ctrl side (drives captured word, valid, status)
// Signals:
//   UNSYNC_BUS [BUS_WIDTH] source-domain data, stable while BUS_EN is high
//   BUS_EN                 asynchronous level enable, rising edge = new word
//   DST_RDY                consumer ready
//   OVR_CLR                clears the sticky overrun flag
//   SYNC_BUS   [BUS_WIDTH] captured word
//   SYNC_VLD               captured word is valid
//   OVERRUN                sticky flag: a word was dropped
//   BUSY                   controller is waiting for the consumer
// ---------------------------------------------------------------------------
interface bus_sync_ctrl_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic                 BUS_EN;
    logic                 DST_RDY;
    logic                 OVR_CLR;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 SYNC_VLD;
    logic                 OVERRUN;
    logic                 BUSY;

    modport master (
        output UNSYNC_BUS,
        output BUS_EN,
        output DST_RDY,
        output OVR_CLR,
        input  SYNC_BUS,
        input  SYNC_VLD,
        input  OVERRUN,
        input  BUSY
    );

    modport slave (
        input  UNSYNC_BUS,
        input  BUS_EN,
        input  DST_RDY,
        input  OVR_CLR,
        output SYNC_BUS,
        output SYNC_VLD,
        output OVERRUN,
        output BUSY
    );
endinterface

// File: rtl/bus_sync_ctrl.sv
// ---------------------------------------------------------------------------
// bus_sync_ctrl
// Multi-bit bus synchronizer controller for one crossing into the CLK domain.
// BUS_EN is passed through a NUM_STAGES flop chain; its synchronized rising
// edge captures UNSYNC_BUS into a holding register, which is then offered to
// a consumer with a valid/ready handshake. A word arriving while the previous
// one is still unaccepted is dropped and flagged by the sticky OVERRUN bit.
// Ports:
//   CLK  destination-domain clock
//   RST  synchronous active-high reset
//   bus  bus_sync_ctrl_if.slave (UNSYNC_BUS, BUS_EN, DST_RDY, OVR_CLR in;
//        SYNC_BUS, SYNC_VLD, OVERRUN, BUSY out)
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module bus_sync_ctrl #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    bus_sync_ctrl_if.slave       bus
);

    generate
        if ((NUM_STAGES < 2) || (NUM_STAGES > 4)) begin : g_bad_stages
            $error("bus_sync_ctrl: NUM_STAGES must be in 2..4");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [NUM_STAGES-1:0] sync_r;
    logic                  en_prev_r;
    logic                  sync_en_s;
    logic                  en_pulse_s;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [BUS_WIDTH-1:0]  sync_bus_r;
    logic [BUS_WIDTH-1:0]  sync_bus_nxt_s;
    logic                  sync_vld_r;
    logic                  sync_vld_nxt_s;
    logic                  overrun_r;
    logic                  overrun_nxt_s;
    logic                  ovr_set_s;

    assign sync_en_s  = sync_r[NUM_STAGES-1];
    // One-cycle pulse on the synchronized rising edge of BUS_EN.
    assign en_pulse_s = sync_en_s & ~en_prev_r;

    // Synchronizer chain on BUS_EN plus the edge-detect delay flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r    <= {NUM_STAGES{1'b0}};
            en_prev_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[NUM_STAGES-2:0], bus.BUS_EN};
            en_prev_r <= sync_en_s;
        end
    end

    // Next-state, holding-register and overrun decisions.
    always_comb begin
        state_nxt_s    = state_r;
        sync_bus_nxt_s = sync_bus_r;
        sync_vld_nxt_s = sync_vld_r;
        ovr_set_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (en_pulse_s) begin
                    sync_bus_nxt_s = bus.UNSYNC_BUS;
                    sync_vld_nxt_s = 1'b1;
                    state_nxt_s    = ST_WAIT;
                end else begin
                    sync_vld_nxt_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus.DST_RDY) begin
                    if (en_pulse_s) begin
                        // Current word leaves and the new one is loaded at
                        // the same edge, so valid never drops.
                        sync_bus_nxt_s = bus.UNSYNC_BUS;
                        sync_vld_nxt_s = 1'b1;
                    end else begin
                        sync_vld_nxt_s = 1'b0;
                        state_nxt_s    = ST_IDLE;
                    end
                end else begin
                    if (en_pulse_s) begin
                        // Holding register is occupied: drop the new word.
                        ovr_set_s = 1'b1;
                    end else begin
                        ovr_set_s = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                sync_vld_nxt_s = 1'b0;
            end
        endcase

        // Setting the flag wins over a simultaneous clear.
        if (ovr_set_s) begin
            overrun_nxt_s = 1'b1;
        end else if (bus.OVR_CLR) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // FSM state and registered outputs; reset discards any pending word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            sync_bus_r <= {BUS_WIDTH{1'b0}};
            sync_vld_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sync_bus_r <= sync_bus_nxt_s;
            sync_vld_r <= sync_vld_nxt_s;
            overrun_r  <= overrun_nxt_s;
        end
    end

    assign bus.SYNC_BUS = sync_bus_r;
    assign bus.SYNC_VLD = sync_vld_r;
    assign bus.OVERRUN  = overrun_r;
    assign bus.BUSY     = (state_r == ST_WAIT);

endmodule

// File: tb/tb_bus_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_sync_ctrl
// Directed bench for bus_sync_ctrl. Inputs change 1 ns after a rising edge
// and outputs are observed at the same point, so each observation reflects
// the edge just taken. "E0" is the first edge that samples BUS_EN high.
// A second instance with NUM_STAGES=3 checks the longer latency.
// ---------------------------------------------------------------------------
module tb_bus_sync_ctrl;

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    bus_sync_ctrl_if #(.BUS_WIDTH(8)) b2 ();
    bus_sync_ctrl_if #(.BUS_WIDTH(8)) b3 ();

    bus_sync_ctrl #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut2 (
        .CLK (CLK),
        .RST (RST),
        .bus (b2.slave)
    );

    bus_sync_ctrl #(.BUS_WIDTH(8), .NUM_STAGES(3)) dut3 (
        .CLK (CLK),
        .RST (RST),
        .bus (b3.slave)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        b2.UNSYNC_BUS = 8'h00; b2.BUS_EN = 1'b0; b2.DST_RDY = 1'b0; b2.OVR_CLR = 1'b0;
        b3.UNSYNC_BUS = 8'h00; b3.BUS_EN = 1'b0; b3.DST_RDY = 1'b0; b3.OVR_CLR = 1'b0;
        tick(3);
        total++; if (b2.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", b2.SYNC_VLD); end
        total++; if (b2.SYNC_BUS !== 8'h00) begin bad++; $display("FAIL reset_bus: got %h want 00", b2.SYNC_BUS); end
        total++; if (b2.OVERRUN !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", b2.OVERRUN); end
        total++; if (b2.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", b2.BUSY); end
        total++; if (b3.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL reset_vld3: got %b want 0", b3.SYNC_VLD); end
        RST = 1'b0;
        tick(2);
    endtask

    task automatic test_basic_capture();
        b2.UNSYNC_BUS = 8'hA5; b2.DST_RDY = 1'b1; b2.BUS_EN = 1'b1;
        tick(2); // E0, E0+1
        total++; if (b2.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL basic_early_vld: got %b want 0", b2.SYNC_VLD); end
        tick(1); // E0+2
        total++; if (b2.SYNC_VLD !== 1'b1) begin bad++; $display("FAIL basic_vld: got %b want 1", b2.SYNC_VLD); end
        total++; if (b2.SYNC_BUS !== 8'hA5) begin bad++; $display("FAIL basic_bus: got %h want a5", b2.SYNC_BUS); end
        total++; if (b2.BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", b2.BUSY); end
        tick(1); // E0+3: transfer done
        total++; if (b2.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL basic_vld_drop: got %b want 0", b2.SYNC_VLD); end
        total++; if (b2.SYNC_BUS !== 8'hA5) begin bad++; $display("FAIL basic_bus_hold: got %h want a5", b2.SYNC_BUS); end
        total++; if (b2.OVERRUN !== 1'b0) begin bad++; $display("FAIL basic_ovr: got %b want 0", b2.OVERRUN); end
        b2.BUS_EN = 1'b0; b2.DST_RDY = 1'b0;
        tick(5);
    endtask

    task automatic test_backpressure();
        int hold_bad;
        b2.UNSYNC_BUS = 8'h3C; b2.DST_RDY = 1'b0; b2.BUS_EN = 1'b1;
        tick(3);
        total++; if (b2.SYNC_BUS !== 8'h3C) begin bad++; $display("FAIL bp_capture: got %h want 3c", b2.SYNC_BUS); end
        // Source may move on once the enable drops; the held word must not.
        b2.BUS_EN = 1'b0; b2.UNSYNC_BUS = 8'hFF;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            total++;
            if ((b2.SYNC_VLD !== 1'b1) || (b2.SYNC_BUS !== 8'h3C)) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: got vld=%b bus=%h want vld=1 bus=3c", i, b2.SYNC_VLD, b2.SYNC_BUS);
            end
        end
        b2.DST_RDY = 1'b1;
        tick(1);
        b2.DST_RDY = 1'b0;
        total++; if (b2.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL bp_release_vld: got %b want 0", b2.SYNC_VLD); end
        total++; if (b2.BUSY !== 1'b0) begin bad++; $display("FAIL bp_release_busy: got %b want 0", b2.BUSY); end
        total++; if (b2.SYNC_BUS !== 8'h3C) begin bad++; $display("FAIL bp_release_bus: got %h want 3c", b2.SYNC_BUS); end
        tick(2);
    endtask

    task automatic test_overrun();
        b2.UNSYNC_BUS = 8'h11; b2.DST_RDY = 1'b0; b2.BUS_EN = 1'b1;
        tick(3);
        total++; if (b2.SYNC_BUS !== 8'h11) begin bad++; $display("FAIL ovr_first: got %h want 11", b2.SYNC_BUS); end
        b2.BUS_EN = 1'b0;
        tick(4);
        b2.UNSYNC_BUS = 8'h22; b2.BUS_EN = 1'b1;
        tick(2);
        total++; if (b2.OVERRUN !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", b2.OVERRUN); end
        tick(1);
        total++; if (b2.OVERRUN !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", b2.OVERRUN); end
        total++; if (b2.SYNC_BUS !== 8'h11) begin bad++; $display("FAIL ovr_bus_kept: got %h want 11", b2.SYNC_BUS); end
        total++; if (b2.SYNC_VLD !== 1'b1) begin bad++; $display("FAIL ovr_vld_kept: got %b want 1", b2.SYNC_VLD); end
        b2.OVR_CLR = 1'b1; b2.BUS_EN = 1'b0;
        tick(1);
        total++; if (b2.OVERRUN !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", b2.OVERRUN); end
        // Clear held as a level while a third word is dropped: set wins.
        tick(3);
        b2.UNSYNC_BUS = 8'h33; b2.BUS_EN = 1'b1;
        tick(3);
        total++; if (b2.OVERRUN !== 1'b1) begin bad++; $display("FAIL ovr_set_wins: got %b want 1", b2.OVERRUN); end
        total++; if (b2.SYNC_BUS !== 8'h11) begin bad++; $display("FAIL ovr_bus_kept2: got %h want 11", b2.SYNC_BUS); end
        tick(1);
        total++; if (b2.OVERRUN !== 1'b0) begin bad++; $display("FAIL ovr_level_clear: got %b want 0", b2.OVERRUN); end
        b2.OVR_CLR = 1'b0; b2.DST_RDY = 1'b1; b2.BUS_EN = 1'b0;
        tick(1);
        total++; if (b2.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", b2.SYNC_VLD); end
        b2.DST_RDY = 1'b0;
        tick(5);
    endtask

    task automatic test_back_to_back();
        b2.UNSYNC_BUS = 8'h01; b2.DST_RDY = 1'b0; b2.BUS_EN = 1'b1;
        tick(3);
        total++; if (b2.SYNC_BUS !== 8'h01) begin bad++; $display("FAIL b2b_first: got %h want 01", b2.SYNC_BUS); end
        b2.BUS_EN = 1'b0;
        tick(4);
        b2.UNSYNC_BUS = 8'h02; b2.BUS_EN = 1'b1;
        tick(2); // E0, E0+1: pulse is active until E0+2
        total++; if (b2.SYNC_BUS !== 8'h01) begin bad++; $display("FAIL b2b_pre: got %h want 01", b2.SYNC_BUS); end
        b2.DST_RDY = 1'b1;
        tick(1); // E0+2: transfer of 01 and capture of 02
        total++; if (b2.SYNC_VLD !== 1'b1) begin bad++; $display("FAIL b2b_vld: got %b want 1", b2.SYNC_VLD); end
        total++; if (b2.SYNC_BUS !== 8'h02) begin bad++; $display("FAIL b2b_bus: got %h want 02", b2.SYNC_BUS); end
        total++; if (b2.OVERRUN !== 1'b0) begin bad++; $display("FAIL b2b_ovr: got %b want 0", b2.OVERRUN); end
        tick(1);
        total++; if (b2.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", b2.SYNC_VLD); end
        b2.DST_RDY = 1'b0; b2.BUS_EN = 1'b0;
        tick(5);
    endtask

    task automatic test_long_enable();
        int vld_cycles;
        b2.UNSYNC_BUS = 8'h5A; b2.DST_RDY = 1'b1; b2.BUS_EN = 1'b1;
        vld_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (b2.SYNC_VLD === 1'b1) vld_cycles++;
        end
        total++; if (vld_cycles != 1) begin bad++; $display("FAIL long_en_captures: got %0d want 1", vld_cycles); end
        total++; if (b2.SYNC_BUS !== 8'h5A) begin bad++; $display("FAIL long_en_bus: got %h want 5a", b2.SYNC_BUS); end
        b2.BUS_EN = 1'b0; b2.DST_RDY = 1'b0;
        tick(5);
    endtask

    task automatic test_reset_mid();
        b2.UNSYNC_BUS = 8'h77; b2.DST_RDY = 1'b0; b2.BUS_EN = 1'b1;
        tick(3);
        b2.BUS_EN = 1'b0;
        tick(4);
        b2.UNSYNC_BUS = 8'h88; b2.BUS_EN = 1'b1;
        tick(3);
        total++; if (b2.OVERRUN !== 1'b1) begin bad++; $display("FAIL rstmid_pre_ovr: got %b want 1", b2.OVERRUN); end
        RST = 1'b1; b2.BUS_EN = 1'b0;
        tick(1);
        RST = 1'b0;
        total++; if (b2.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL rstmid_vld: got %b want 0", b2.SYNC_VLD); end
        total++; if (b2.SYNC_BUS !== 8'h00) begin bad++; $display("FAIL rstmid_bus: got %h want 00", b2.SYNC_BUS); end
        total++; if (b2.OVERRUN !== 1'b0) begin bad++; $display("FAIL rstmid_ovr: got %b want 0", b2.OVERRUN); end
        total++; if (b2.BUSY !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", b2.BUSY); end
        tick(3);
        b2.UNSYNC_BUS = 8'hF0; b2.DST_RDY = 1'b1; b2.BUS_EN = 1'b1;
        tick(2);
        total++; if (b2.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL rstmid_early: got %b want 0", b2.SYNC_VLD); end
        tick(1);
        total++; if (b2.SYNC_VLD !== 1'b1) begin bad++; $display("FAIL rstmid_vld2: got %b want 1", b2.SYNC_VLD); end
        total++; if (b2.SYNC_BUS !== 8'hF0) begin bad++; $display("FAIL rstmid_bus2: got %h want f0", b2.SYNC_BUS); end
        total++; if (b2.OVERRUN !== 1'b0) begin bad++; $display("FAIL rstmid_ovr2: got %b want 0", b2.OVERRUN); end
        b2.BUS_EN = 1'b0; b2.DST_RDY = 1'b0;
        tick(5);
    endtask

    task automatic test_stages3();
        b3.UNSYNC_BUS = 8'hA5; b3.DST_RDY = 1'b1; b3.BUS_EN = 1'b1;
        tick(3); // E0..E0+2
        total++; if (b3.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL s3_early: got %b want 0", b3.SYNC_VLD); end
        tick(1); // E0+3
        total++; if (b3.SYNC_VLD !== 1'b1) begin bad++; $display("FAIL s3_vld: got %b want 1", b3.SYNC_VLD); end
        total++; if (b3.SYNC_BUS !== 8'hA5) begin bad++; $display("FAIL s3_bus: got %h want a5", b3.SYNC_BUS); end
        tick(1);
        total++; if (b3.SYNC_VLD !== 1'b0) begin bad++; $display("FAIL s3_drop: got %b want 0", b3.SYNC_VLD); end
        b3.BUS_EN = 1'b0; b3.DST_RDY = 1'b0;
        tick(2);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        #1;
        test_reset();
        test_basic_capture();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_long_enable();
        test_reset_mid();
        test_stages3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
